// File: rtl/fir_sample_loader_if.sv
// rtl/fir_sample_loader_if.sv - sample stream, sample-memory write and FIR control bundle for fir_sample_loader
interface fir_sample_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              arm;
  logic [ADDR_W-1:0] sample_count;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              fir_start;
  logic              fir_done;
  logic              busy;
  logic              load_done;
  logic              err;
  logic [ADDR_W-1:0] loaded_count;
  logic [31:0]       fir_cycles;

  modport slave (
    input  arm, sample_count, s_data, s_valid, fir_done,
    output s_ready, mem_we, mem_addr, mem_din, fir_start,
           busy, load_done, err, loaded_count, fir_cycles
  );

  modport master (
    output arm, sample_count, s_data, s_valid, fir_done,
    input  s_ready, mem_we, mem_addr, mem_din, fir_start,
           busy, load_done, err, loaded_count, fir_cycles
  );
endinterface

// File: rtl/fir_sample_loader.sv
// rtl/fir_sample_loader.sv - loads a sample stream into shared memory, kicks the FIR and times its run
module fir_sample_loader #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 10,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MAX_SAMPLES = 512
) (
  input logic                clk,
  input logic                rst,
  fir_sample_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    KICK  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [31:0]       CYC_MAX = 32'hFFFF_FFFF;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] loaded_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_we_q;
  logic              fir_start_q;
  logic              load_done_q;
  logic              err_q;
  logic              done_q;
  logic [31:0]       fir_cycles_q;

  logic count_bad;
  logic done_rise;
  logic accept;
  logic arm_ok;
  logic arm_bad;

  assign count_bad = (bus.sample_count == '0) || (32'(bus.sample_count) > MAX_SAMPLES);
  assign done_rise = bus.fir_done & ~done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    arm_ok    = 1'b0;
    arm_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) begin
          if (count_bad) begin
            arm_bad = 1'b1;
          end else begin
            arm_ok    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          accept = 1'b1;
          if (idx == cnt - ONE_A) begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH:   state_nxt = KICK;
      KICK:    state_nxt = WAIT;
      WAIT: begin
        if (done_rise) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only a rising edge of fir_done ends the wait, so a level left over from a prior run is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      idx          <= '0;
      loaded_q     <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
      fir_start_q  <= 1'b0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      fir_cycles_q <= '0;
    end else begin
      done_q      <= bus.fir_done;
      mem_we_q    <= accept;
      fir_start_q <= (state == FLUSH);
      load_done_q <= (state == WAIT) && done_rise;

      if (arm_bad) begin
        err_q <= 1'b1;
      end
      if (arm_ok) begin
        err_q    <= 1'b0;
        cnt      <= bus.sample_count;
        idx      <= '0;
        loaded_q <= '0;
      end

      if (accept) begin
        mem_addr_q <= BASE_A + idx;
        mem_din_q  <= bus.s_data;
        idx        <= idx + ONE_A;
        loaded_q   <= loaded_q + ONE_A;
      end

      if (state == KICK) begin
        fir_cycles_q <= '0;
      end else if (state == WAIT && fir_cycles_q != CYC_MAX) begin
        fir_cycles_q <= fir_cycles_q + 32'd1;
      end
    end
  end

  assign bus.s_ready      = (state == LOAD);
  assign bus.busy         = (state != IDLE);
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_din      = mem_din_q;
  assign bus.fir_start    = fir_start_q;
  assign bus.load_done    = load_done_q;
  assign bus.err          = err_q;
  assign bus.loaded_count = loaded_q;
  assign bus.fir_cycles   = fir_cycles_q;

endmodule

// File: tb/tb_fir_sample_loader.sv
// tb/tb_fir_sample_loader.sv - scoreboard bench for fir_sample_loader at base 0 and at a wrapping base
module tb_fir_sample_loader;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   start_cnt;
  logic prev_start;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  fir_sample_loader_if #(.DATA_W(8), .ADDR_W(10)) bus0 ();
  fir_sample_loader_if #(.DATA_W(8), .ADDR_W(10)) bus1 ();

  fir_sample_loader #(.DATA_W(8), .ADDR_W(10), .BASE_ADDR(0), .MAX_SAMPLES(512)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fir_sample_loader #(.DATA_W(8), .ADDR_W(10), .BASE_ADDR(1022), .MAX_SAMPLES(512)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus1.arm          = bus0.arm;
  assign bus1.sample_count = bus0.sample_count;
  assign bus1.s_data       = bus0.s_data;
  assign bus1.s_valid      = bus0.s_valid;
  assign bus1.fir_done     = bus0.fir_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Write scoreboard: every accept pushed by the driver must show up as a write exactly one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (bus0.mem_we === 1'b1) begin
        if (q.size() == 0) begin
          check("we0_unexpected", bus0.mem_we, 0);
        end else begin
          e = q.pop_front();
          check("addr0", bus0.mem_addr, 32'(e.idx % 1024));
          check("din0", bus0.mem_din, e.data);
          check("we_latency", cyc, e.cyc + 1);
          check("we1", bus1.mem_we, 1);
          check("addr1_wrap", bus1.mem_addr, 32'((1022 + e.idx) % 1024));
          check("din1", bus1.mem_din, e.data);
        end
      end else if (bus1.mem_we !== 1'b0) begin
        check("we1_unexpected", bus1.mem_we, 0);
      end
      if (bus0.fir_start === 1'b1) begin
        start_cnt++;
        check("start_single", prev_start, 0);
        check("start1", bus1.fir_start, 1);
      end
      prev_start = bus0.fir_start;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_run(input int n, input logic [7:0] d0, input logic [15:0] pat,
                          input int plen, input int done_n);
    int sent;
    int p;
    int sc0;
    sc0 = start_cnt;
    bus0.arm          = 1'b1;
    bus0.sample_count = 10'(n);
    bus0.s_valid      = 1'b0;
    @(negedge clk);
    bus0.arm = 1'b0;
    check("arm_busy", bus0.busy, 1);
    check("arm_err", bus0.err, 0);
    check("arm_loaded", bus0.loaded_count, 0);
    check("arm_load_done", bus0.load_done, 0);
    sent = 0;
    p    = 0;
    while (sent < n && p < 64) begin
      check("load_s_ready", bus0.s_ready, 1);
      if (pat[p % plen]) begin
        bus0.s_valid = 1'b1;
        bus0.s_data  = d0 + 8'(sent * 16);
        q.push_back('{cyc: cyc, idx: sent, data: bus0.s_data});
        sent++;
      end else begin
        bus0.s_valid = 1'b0;
        bus0.s_data  = 8'($urandom);
      end
      p++;
      @(negedge clk);
    end
    bus0.s_valid = 1'b0;
    check("flush_s_ready", bus0.s_ready, 0);
    check("flush_start", bus0.fir_start, 0);
    check("loaded_count", bus0.loaded_count, n);
    check("loaded_count1", bus1.loaded_count, n);
    @(negedge clk);
    check("kick_start", bus0.fir_start, 1);
    check("kick_busy", bus0.busy, 1);
    for (int k = 1; k <= done_n; k++) begin
      @(negedge clk);
      check("wait_start", bus0.fir_start, 0);
      check("wait_load_done", bus0.load_done, 0);
      if (k == 1) check("wait_cycles0", bus0.fir_cycles, 0);
      bus0.fir_done = (k == done_n);
    end
    @(negedge clk);
    check("load_done", bus0.load_done, 1);
    check("done_busy", bus0.busy, 0);
    check("fir_cycles", bus0.fir_cycles, done_n);
    check("fir_cycles1", bus1.fir_cycles, done_n);
    check("start_count", start_cnt, sc0 + 1);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    start_cnt  = 0;
    prev_start = 1'b0;

    rst               = 1'b0;
    bus0.arm          = 1'b1;
    bus0.sample_count = 10'd4;
    bus0.s_valid      = 1'b1;
    bus0.s_data       = 8'h55;
    bus0.fir_done     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", bus0.mem_we, 0);
    check("rst_mem_addr", bus0.mem_addr, 0);
    check("rst_mem_din", bus0.mem_din, 0);
    check("rst_fir_start", bus0.fir_start, 0);
    check("rst_load_done", bus0.load_done, 0);
    check("rst_err", bus0.err, 0);
    check("rst_loaded", bus0.loaded_count, 0);
    check("rst_fir_cycles", bus0.fir_cycles, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_s_ready", bus0.s_ready, 0);
    check("rst_busy1", bus1.busy, 0);
    rst          = 1'b1;
    bus0.arm     = 1'b0;
    bus0.s_valid = 1'b0;
    idle(2);

    load_run(4, 8'h10, 16'hFFFF, 1, 5);
    idle(2);

    load_run(4, 8'h05, 16'h0059, 7, 3);

    bus0.arm          = 1'b1;
    bus0.sample_count = 10'd0;
    @(negedge clk);
    check("ill0_err", bus0.err, 1);
    check("ill0_busy", bus0.busy, 0);
    bus0.sample_count = 10'd513;
    @(negedge clk);
    check("ill513_err", bus0.err, 1);
    check("ill513_busy", bus0.busy, 0);
    check("ill513_err1", bus1.err, 1);
    bus0.arm = 1'b0;
    @(negedge clk);

    load_run(3, 8'hA1, 16'hFFFF, 1, 37);
    load_run(4, 8'h0F, 16'hFFFF, 1, 2);
    idle(3);

    begin
      int sc0;
      bus0.arm          = 1'b1;
      bus0.sample_count = 10'd4;
      @(negedge clk);
      bus0.arm = 1'b0;
      check("abort_arm_busy", bus0.busy, 1);
      for (int i = 0; i < 2; i++) begin
        check("abort_s_ready", bus0.s_ready, 1);
        bus0.s_valid = 1'b1;
        bus0.s_data  = 8'hE0 + 8'(i);
        q.push_back('{cyc: cyc, idx: i, data: bus0.s_data});
        @(negedge clk);
      end
      sc0          = start_cnt;
      rst          = 1'b0;
      bus0.s_data  = 8'hEE;
      bus0.arm     = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_busy", bus0.busy, 0);
      check("abort_s_ready_low", bus0.s_ready, 0);
      check("abort_loaded", bus0.loaded_count, 0);
      rst          = 1'b1;
      bus0.s_valid = 1'b0;
      bus0.arm     = 1'b0;
      idle(4);
      check("abort_no_start", start_cnt, sc0);
      check("abort_idle", bus0.busy, 0);
    end

    load_run(2, 8'h70, 16'hFFFF, 1, 4);
    idle(2);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 10000", cyc);
    $fatal(1);
  end

endmodule
